// File: rtl/sim_halt_dump_ctrl_pkg.sv
// Shared types and constants for the run/halt debug controller.
// Imported by the controller top and the testbench.
package sim_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DUMP = 2'd2,
        ST_DONE = 2'd3
    } dbg_state_e;

    localparam logic [1:0] HC_NONE = 2'd0;
    localparam logic [1:0] HC_BP   = 2'd1;
    localparam logic [1:0] HC_TMO  = 2'd2;

    // PC word and instruction word precede the registers.
    localparam int HDR_WORDS = 2;

    // Index of the final word of a snapshot holding nreg registers.
    function automatic logic [5:0] last_idx(input int nreg);
        return 6'(nreg + HDR_WORDS - 1);
    endfunction

endpackage

// File: rtl/sim_halt_dump_ctrl_if.sv
// Snapshot stream port: valid/ready handshake carrying one word
// plus its position in the current dump.
interface sim_halt_dump_ctrl_if #(
    parameter int REG_W = 32
);
    logic             valid;
    logic             ready;
    logic [REG_W-1:0] data;
    logic [5:0]       idx;

    modport master (
        output valid,
        output data,
        output idx,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  idx,
        output ready
    );
endinterface

// File: rtl/sim_halt_dump_ctrl_pc_bp_match.sv
// Breakpoint comparator bank: flags when the PC equals any
// enabled breakpoint slot.
module pc_bp_match #(
    parameter int NUM_BP = 4,
    parameter int PC_W   = 32
) (
    input  logic [PC_W-1:0]        pc_i,
    input  logic [NUM_BP*PC_W-1:0] bp_addr_i,
    input  logic [NUM_BP-1:0]      bp_en_i,
    output logic                   hit_o
);

    // OR-reduce the per-slot address matches of enabled slots.
    always_comb begin
        hit_o = 1'b0;
        for (int k = 0; k < NUM_BP; k++) begin
            if (bp_en_i[k] &&
                (bp_addr_i[k*PC_W +: PC_W] == pc_i)) begin
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sim_halt_dump_ctrl.sv
// Run/halt controller: halts the CPU on breakpoint or cycle limit
// and streams PC, instruction and registers. Macro: HALT_TIMEOUT_EN.
module sim_halt_dump_ctrl
    import sim_dbg_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int NUM_BP = 4,
    parameter int NREG   = 32,
    parameter int REG_W  = 32,
    parameter int CNT_W  = 16,
    localparam int SEL_W = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start_i,
    input  logic [PC_W-1:0]        pc_i,
    input  logic [31:0]            instr_i,
    input  logic [NUM_BP*PC_W-1:0] bp_addr_i,
    input  logic [NUM_BP-1:0]      bp_en_i,
    input  logic [CNT_W-1:0]       cycle_limit_i,
    output logic                   cpu_stall_o,
    output logic [SEL_W-1:0]       reg_sel_o,
    input  logic [REG_W-1:0]       reg_data_i,
    sim_halt_dump_ctrl_if.master   dump,
    output logic [1:0]             halt_cause_o,
    output logic [CNT_W-1:0]       cycle_cnt_o,
    output logic                   done_o
);

    localparam logic [5:0] LAST = last_idx(NREG);

    dbg_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic [5:0]       idx_q, idx_d;
    logic [PC_W-1:0]  pc_lat_q, pc_lat_d;
    logic [31:0]      ins_lat_q, ins_lat_d;
    logic             mask_q, mask_d;
    logic             stall;
    logic             bp_raw;
    logic             hit;
    logic             tmo;

    pc_bp_match #(
        .NUM_BP (NUM_BP),
        .PC_W   (PC_W)
    ) u_match (
        .pc_i      (pc_i),
        .bp_addr_i (bp_addr_i),
        .bp_en_i   (bp_en_i),
        .hit_o     (bp_raw)
    );

    // First RUN cycle after entry ignores breakpoints so a resume
    // from the halted PC can make progress.
    assign hit = bp_raw && !mask_q;

`ifdef HALT_TIMEOUT_EN
    assign tmo = (cycle_limit_i != '0) &&
                 (cnt_q == cycle_limit_i);
`else
    logic unused_limit;
    assign unused_limit = ^cycle_limit_i;
    assign tmo = 1'b0;
`endif

    // State and snapshot registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cause_q   <= HC_NONE;
            idx_q     <= '0;
            pc_lat_q  <= '0;
            ins_lat_q <= '0;
            mask_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            idx_q     <= idx_d;
            pc_lat_q  <= pc_lat_d;
            ins_lat_q <= ins_lat_d;
            mask_q    <= mask_d;
        end
    end

    // Next-state, counter and dump sequencing; stall is the
    // combinational halt so a hit instruction never commits.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cause_d   = cause_q;
        idx_d     = idx_q;
        pc_lat_d  = pc_lat_q;
        ins_lat_d = ins_lat_q;
        mask_d    = mask_q;
        stall     = 1'b1;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    cause_d = HC_NONE;
                    mask_d  = 1'b1;
                end
            end
            ST_RUN: begin
                mask_d = 1'b0;
                if (hit || tmo) begin
                    state_d   = ST_DUMP;
                    pc_lat_d  = pc_i;
                    ins_lat_d = instr_i;
                    cause_d   = hit ? HC_BP : HC_TMO;
                    idx_d     = '0;
                end else begin
                    stall = 1'b0;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DUMP: begin
                if (dump.ready) begin
                    if (idx_q == LAST) begin
                        state_d = ST_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register index tracks the word index past the header.
    always_comb begin
        reg_sel_o = '0;
        if (idx_q >= 6'(HDR_WORDS)) begin
            reg_sel_o = SEL_W'(idx_q - 6'(HDR_WORDS));
        end
    end

    // Word mux: header words from the latches, r0 forced to zero.
    always_comb begin
        dump.data = '0;
        if (state_q == ST_DUMP) begin
            if (idx_q == 6'd0) begin
                dump.data = REG_W'(pc_lat_q);
            end else if (idx_q == 6'd1) begin
                dump.data = REG_W'(ins_lat_q);
            end else if (reg_sel_o != '0) begin
                dump.data = reg_data_i;
            end
        end
    end

    assign dump.valid   = (state_q == ST_DUMP);
    assign dump.idx     = idx_q;
    assign cpu_stall_o  = stall;
    assign halt_cause_o = cause_q;
    assign cycle_cnt_o  = cnt_q;
    assign done_o       = (state_q == ST_DONE);

endmodule
